// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle RV32I datapath: fetch/decode/execute/memory/writeback
// sequencing with bounded memory waits, sticky trap flags and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int OPCODE_W   = 7,
    parameter int ALUOP_W    = 2,
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] OPcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic [1:0]          MemtoReg,
    output logic                PCSource,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp_out,
    output logic                RegWrite,
    output logic                branch,
    output logic                illegal_instr,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_out
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXEC_R    = 4'd3,
        EXEC_I    = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        ALU_WB    = 4'd11,
        TRAP      = 4'd12
    } StateT;

    localparam int                  WCNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0]   WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);
    localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BR     = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);

    StateT             r_state;
    logic [WCNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0]  r_retired;
    logic              r_illegal;
    logic              r_timeout;

    logic w_inWait;
    logic w_expired;

    assign w_inWait  = (r_state == FETCH) || (r_state == MEM_READ) || (r_state == MEM_WRITE);
    assign w_expired = w_inWait && !mem_ready && (r_waitCnt == WAIT_LAST);

    // The wait counter only survives while a memory state keeps stalling; any exit clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_waitCnt <= '0;
            if (w_inWait && !mem_ready) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (w_expired) begin
                r_state   <= TRAP;
                r_timeout <= 1'b1;
            end else begin
                case (r_state)
                    IDLE:   r_state <= FETCH;
                    FETCH:  if (mem_ready) r_state <= DECODE;
                    DECODE: begin
                        case (OPcode)
                            OP_R:              r_state <= EXEC_R;
                            OP_I:              r_state <= EXEC_I;
                            OP_LOAD, OP_STORE: r_state <= MEM_ADDR;
                            OP_BR:             r_state <= BRANCH;
                            OP_JAL:            r_state <= JAL;
                            default: begin
                                r_state   <= TRAP;
                                r_illegal <= 1'b1;
                            end
                        endcase
                    end
                    EXEC_R, EXEC_I: r_state <= ALU_WB;
                    MEM_ADDR: r_state <= (OPcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
                    MEM_READ: if (mem_ready) r_state <= MEM_WB;
                    MEM_WB, ALU_WB, BRANCH, JAL: begin
                        r_state   <= FETCH;
                        r_retired <= r_retired + 1'b1;
                    end
                    MEM_WRITE: begin
                        if (mem_ready) begin
                            r_state   <= FETCH;
                            r_retired <= r_retired + 1'b1;
                        end
                    end
                    TRAP:    r_state <= TRAP;
                    default: r_state <= TRAP;
                endcase
            end
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 2'b00;
        PCSource  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp_out = '0;
        RegWrite  = 1'b0;
        branch    = 1'b0;
        case (r_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: ALUSrcB = 2'b10;
            EXEC_R: begin
                ALUSrcA   = 1'b1;
                ALUOp_out = ALUOP_W'(2'b10);
            end
            EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp_out = ALUOP_W'(2'b11);
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            BRANCH: begin
                branch    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUOp_out = ALUOP_W'(2'b01);
                PCSource  = 1'b1;
                PCWrite   = zero;
            end
            JAL: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
            end
            ALU_WB:  RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign retired       = r_retired;
    assign illegal_instr = r_illegal;
    assign mem_timeout   = r_timeout;
    assign state_out     = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: an instruction-level model predicts the
// state walk, control word, retired count and trap flags for every cycle.
module tb_multicycle_control_unit;

    localparam int WAIT_LIMIT = 16;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4;
    localparam int S_MEM_ADDR = 5, S_MEM_READ = 6, S_MEM_WB = 7, S_MEM_WRITE = 8;
    localparam int S_BRANCH = 9, S_JAL = 10, S_ALU_WB = 11, S_TRAP = 12;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic        clk;
    logic        reset_n;
    logic [6:0]  OPcode;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite;
    logic [1:0]  MemtoReg;
    logic        PCSource, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp_out;
    logic        RegWrite, branch, illegal_instr, mem_timeout;
    logic [31:0] retired;
    logic [3:0]  state_out;
    logic [14:0] ctlWord;

    int          errCount;
    int          checkCount;
    logic [31:0] expRetired;
    bit          expIllegal;
    bit          expTimeout;
    bit          trapped;
    logic [6:0]  legalOps [6];

    multicycle_control_unit #(
        .OPCODE_W  (7),
        .ALUOP_W   (2),
        .WAIT_LIMIT(WAIT_LIMIT),
        .CNT_W     (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .OPcode       (OPcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .IRWrite      (IRWrite),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .PCSource     (PCSource),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp_out    (ALUOp_out),
        .RegWrite     (RegWrite),
        .branch       (branch),
        .illegal_instr(illegal_instr),
        .mem_timeout  (mem_timeout),
        .retired      (retired),
        .state_out    (state_out)
    );

    assign ctlWord = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, PCSource,
                      ALUSrcA, ALUSrcB, ALUOp_out, RegWrite, branch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word each state should present, straight from the datapath control table.
    function automatic logic [14:0] expCtl(input int st, input bit rdy, input bit z);
        logic pcw, irw, iord, mr, mw, pcs, asa, rw, br;
        logic [1:0] m2r, asb, aop;
        {pcw, irw, iord, mr, mw, pcs, asa, rw, br} = '0;
        m2r = 2'b00;
        asb = 2'b00;
        aop = 2'b00;
        case (st)
            S_FETCH:     begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:    asb = 2'b10;
            S_EXEC_R:    begin asa = 1; aop = 2'b10; end
            S_EXEC_I:    begin asa = 1; asb = 2'b10; aop = 2'b11; end
            S_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
            S_MEM_READ:  begin mr = 1; iord = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 2'b01; end
            S_MEM_WRITE: begin mw = 1; iord = 1; end
            S_BRANCH:    begin br = 1; asa = 1; aop = 2'b01; pcs = 1; pcw = z; end
            S_JAL:       begin pcw = 1; pcs = 1; rw = 1; m2r = 2'b10; end
            S_ALU_WB:    rw = 1;
            default:     ;
        endcase
        return {pcw, irw, iord, mr, mw, m2r, pcs, asa, asb, aop, rw, br};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Drives one cycle's inputs just after the rising edge and samples at the falling edge.
    task automatic applyStimulus(input int expSt, input bit rdy, input bit z);
        mem_ready = rdy;
        zero      = z;
        #4;
        checkOutput("state", 32'(state_out), 32'(expSt));
        checkOutput("ctl", 32'(ctlWord), 32'(expCtl(expSt, rdy, z)));
        checkOutput("retired", retired, expRetired);
        checkOutput("flags", 32'({illegal_instr, mem_timeout}), 32'({expIllegal, expTimeout}));
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        reset_n = 1'b0;
        #1;
        checkOutput({tag, "_state"}, 32'(state_out), 32'(S_IDLE));
        checkOutput({tag, "_ctl"}, 32'(ctlWord), 32'd0);
        checkOutput({tag, "_retired"}, retired, 32'd0);
        checkOutput({tag, "_flags"}, 32'({illegal_instr, mem_timeout}), 32'd0);
        expRetired = '0;
        expIllegal = 1'b0;
        expTimeout = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(S_IDLE, 1'($urandom), 1'($urandom));
    endtask

    // A memory access that becomes ready after 'stalls' idle cycles, or times out.
    task automatic waitPhase(input int st, input int stalls, output bit tr);
        bit rdy;
        tr = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            rdy = (i >= stalls);
            applyStimulus(st, rdy, 1'($urandom));
            if (rdy) break;
            if (i == WAIT_LIMIT - 1) begin
                tr         = 1'b1;
                expTimeout = 1'b1;
            end
        end
    endtask

    task automatic runInstr(input logic [6:0] op, input int fStalls, input int mStalls,
                            input bit z, output bit tr);
        OPcode = 7'($urandom);
        waitPhase(S_FETCH, fStalls, tr);
        if (tr) return;
        OPcode = op;
        applyStimulus(S_DECODE, 1'($urandom), 1'($urandom));
        case (op)
            OP_R: begin
                applyStimulus(S_EXEC_R, 1'($urandom), 1'($urandom));
                applyStimulus(S_ALU_WB, 1'($urandom), 1'($urandom));
                expRetired++;
            end
            OP_I: begin
                applyStimulus(S_EXEC_I, 1'($urandom), 1'($urandom));
                applyStimulus(S_ALU_WB, 1'($urandom), 1'($urandom));
                expRetired++;
            end
            OP_LOAD: begin
                applyStimulus(S_MEM_ADDR, 1'($urandom), 1'($urandom));
                waitPhase(S_MEM_READ, mStalls, tr);
                if (tr) return;
                applyStimulus(S_MEM_WB, 1'($urandom), 1'($urandom));
                expRetired++;
            end
            OP_STORE: begin
                applyStimulus(S_MEM_ADDR, 1'($urandom), 1'($urandom));
                waitPhase(S_MEM_WRITE, mStalls, tr);
                if (!tr) expRetired++;
            end
            OP_BR: begin
                applyStimulus(S_BRANCH, 1'($urandom), z);
                expRetired++;
            end
            OP_JAL: begin
                applyStimulus(S_JAL, 1'($urandom), 1'($urandom));
                expRetired++;
            end
            default: begin
                expIllegal = 1'b1;
                tr         = 1'b1;
            end
        endcase
    endtask

    task automatic trapHold(input int n);
        for (int i = 0; i < n; i++) begin
            OPcode = 7'($urandom);
            applyStimulus(S_TRAP, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errCount   = 0;
        checkCount = 0;
        expRetired = '0;
        expIllegal = 1'b0;
        expTimeout = 1'b0;
        reset_n    = 1'b0;
        OPcode     = '0;
        zero       = 1'b0;
        mem_ready  = 1'b0;
        legalOps   = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL};

        doReset("rst0");
        runInstr(OP_R, 0, 0, 1'b0, trapped);
        runInstr(OP_LOAD, 0, 3, 1'b0, trapped);
        runInstr(OP_BR, 0, 0, 1'b1, trapped);
        runInstr(OP_BR, 1, 0, 1'b0, trapped);
        runInstr(OP_I, 2, 0, 1'b0, trapped);
        runInstr(OP_JAL, 0, 0, 1'b0, trapped);
        runInstr(OP_STORE, 0, 2, 1'b0, trapped);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 40; n++) begin
            int fs, ms;
            fs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WAIT_LIMIT - 1) : $urandom_range(0, 3);
            ms = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WAIT_LIMIT - 1) : $urandom_range(0, 4);
            runInstr(legalOps[$urandom_range(0, 5)], fs, ms, 1'($urandom), trapped);
        end

        $display("[TB] reset during MEM_WRITE");
        waitPhase(S_FETCH, 0, trapped);
        OPcode = OP_STORE;
        applyStimulus(S_DECODE, 1'($urandom), 1'($urandom));
        applyStimulus(S_MEM_ADDR, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 3; i++) applyStimulus(S_MEM_WRITE, 1'b0, 1'($urandom));
        mem_ready = 1'b0;
        #2;
        checkOutput("midWrStrobe", 32'(MemWrite), 32'd1);
        doReset("midWr");

        $display("[TB] store timeout");
        runInstr(OP_STORE, 0, 100, 1'b0, trapped);
        trapHold(20);
        doReset("rstTo");

        $display("[TB] store ready on last allowed cycle");
        runInstr(OP_STORE, 0, WAIT_LIMIT - 1, 1'b0, trapped);
        runInstr(OP_R, 0, 0, 1'b0, trapped);

        $display("[TB] fetch timeout");
        runInstr(OP_R, 30, 0, 1'b0, trapped);
        trapHold(5);
        doReset("rstFt");

        $display("[TB] illegal opcode");
        runInstr(OP_JAL, 0, 0, 1'b0, trapped);
        runInstr(7'b1111111, 0, 0, 1'b0, trapped);
        trapHold(20);
        doReset("rstIll");
        runInstr(OP_I, 0, 0, 1'b0, trapped);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Successor to the single-cycle decoder: a Moore FSM that sequences a multicycle RV32I datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Adds I-ALU, load, store, beq and jal to R-type support, with memory ready handshakes, a bounded memory wait timeout and a sticky trap.
- Exposes an instruction-retired counter.
- Sits between the instruction register opcode field and all datapath mux/enable controls.

Parameters:
OPCODE_W, 7, opcode field width
ALUOP_W, 2, ALUOp_out width
WAIT_LIMIT, 16, max cycles a memory state waits for mem_ready before trapping (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
OPcode  input  OPCODE_W  opcode of IR (valid from DECODE onward)
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current read/write this cycle
PCWrite  output  1  PC load enable
IRWrite  output  1  instruction register load enable
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead, MemWrite  output  1 each  memory strobes
MemtoReg  output  2  00=ALUOut, 01=MDR, 10=OldPC+4
PCSource  output  1  0=ALU result, 1=ALUOut (target)
ALUSrcA  output  1  0=OldPC/PC, 1=rs1
ALUSrcB  output  2  00=rs2, 01=const 4, 10=imm
ALUOp_out  output  ALUOP_W  00=add, 01=sub, 10=R funct, 11=I funct
RegWrite, branch  output  1 each  register write enable / branch state flag
illegal_instr, mem_timeout  output  1 each  sticky trap causes
retired  output  CNT_W  instructions completed
state_out  output  4  current state encoding (debug)

Behaviour:
- States/encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_READ 6, MEM_WB 7, MEM_WRITE 8, BRANCH 9, JAL 10, ALU_WB 11, TRAP 12.
- Reset (async, reset_n=0): state=IDLE, retired=0, illegal_instr=0, mem_timeout=0, wait counter=0. All outputs are 0 in IDLE.
- IDLE -> FETCH on the first clock edge with reset_n=1.
- Outputs are a pure function of the state register, plus mem_ready/zero gating where stated. Unlisted outputs are 0 in each state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. When mem_ready=1: IRWrite=1, PCWrite=1, PCSource=0, then -> DECODE. Otherwise stay.
- DECODE: ALUSrcA=0 (OldPC), ALUSrcB=10, ALUOp=00 (target into ALUOut). Next state by OPcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other -> TRAP with illegal_instr set
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, -> ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11, -> ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=00, -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, -> MEM_READ if load, MEM_WRITE if store.
- MEM_READ: MemRead=1, IorD=1; on mem_ready -> MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=01, -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1; on mem_ready -> FETCH.
- BRANCH: branch=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=zero, -> FETCH.
- JAL: PCWrite=1, PCSource=1, RegWrite=1, MemtoReg=10, -> FETCH.
- Wait counter (FETCH, MEM_READ, MEM_WRITE only):
  - Clears on entering any of these states.
  - Increments each cycle mem_ready=0.
  - If it reaches WAIT_LIMIT-1 with mem_ready=0: -> TRAP, mem_timeout set. mem_ready=1 on that same cycle wins; no trap.
- TRAP: all strobes 0. Held until reset. Trap flags are sticky until reset.
- retired: increments (mod 2^CNT_W) on every transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE, BRANCH, JAL. Not incremented from IDLE or on trap.
- Reset asserted mid-instruction: immediate IDLE, all outputs 0, no partial write strobe held.

Test Plan:
- Reset then OPcode=0110011, mem_ready=1 always -> states 0,1,2,3,11,1. RegWrite=1 only in ALU_WB. retired=1 after 5 cycles.
- Load (0000011), mem_ready low 3 cycles in MEM_READ -> MemRead,IorD held 4 cycles. MEM_WB has MemtoReg=01. retired increments once.
- beq (1100011): zero=1 -> PCWrite=1,PCSource=1 in BRANCH. Repeat with zero=0 -> PCWrite=0. Both retire.
- OPcode=1111111 in DECODE -> TRAP (12), illegal_instr=1, no further strobes for 20 cycles, retired unchanged.
- Store with mem_ready stuck 0, WAIT_LIMIT=16 -> MemWrite high exactly 16 cycles, then TRAP, mem_timeout=1. Variant with mem_ready=1 on the 16th cycle -> FETCH, no trap.
- reset_n pulsed low during MEM_WRITE -> MemWrite drops asynchronously, state=0, counters/flags cleared.
